gray_stream_rx: RTL and testbench

//  Receive end of the NBIT Gray-coded data path: accepts a Gray-coded sample stream over valid/ready,

---
 rtl/gray_stream_rx.sv | 203 ++++++++++++++++++++
 tb/tb_gray_stream_rx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_stream_rx.sv
// Gray-coded stream receiver: decodes samples to binary, checks single-bit steps, tracks lock, counts errors.
// Optional macro GRAY_DIR_CHECK_EN enables step-direction latching and checking (o_dir).
module gray_stream_rx #(
    parameter int NBIT      = 8,
    parameter int ERR_CNT_W = 8,
    parameter int LOCK_CNT  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NBIT-1:0]      i_gray,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [NBIT-1:0]      o_bin,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_locked,
    output logic                 o_err_pulse,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    input  logic                 i_clr_err,
    output logic                 o_dir,
    output logic [1:0]           o_dbg_state
);

    // Handshake: input transfer when i_valid & o_ready, output transfer when o_valid & i_ready.
    // The output register refills on the same edge it drains, so o_ready = ~o_valid | i_ready.

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int GCW = $clog2(LOCK_CNT + 1);

    function automatic logic [NBIT-1:0] gray2bin(input logic [NBIT-1:0] g);
        logic [NBIT-1:0] b;
        b[NBIT-1] = g[NBIT-1];
        for (int k = NBIT - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    state_t                state_q, state_d;
    logic [GCW-1:0]        good_q, good_d;
    logic [NBIT-1:0]       gprev_q, gprev_d;
    logic                  valid_q, valid_d;
    logic [NBIT-1:0]       bin_q, bin_d;
    logic                  err_q, err_d;
    logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;

    logic                  accept;
    logic [NBIT-1:0]       bin_new;
    logic [NBIT-1:0]       step_diff;
    logic                  step_same;
    logic                  step_one;
    logic                  dir_bad;
    logic                  good;
    logic                  bad;
    logic                  bad_acc;

`ifdef GRAY_DIR_CHECK_EN
    logic                  dir_q, dir_d;
    logic                  dir_vld_q, dir_vld_d;
    logic [NBIT-1:0]       bin_prev;
    logic                  step_up;
    localparam logic [NBIT-1:0] ONE = NBIT'(1);
`endif

    assign o_ready     = ~valid_q | i_ready;
    assign accept      = i_valid & o_ready;
    assign bin_new     = gray2bin(i_gray);
    assign step_diff   = i_gray ^ gprev_q;
    assign step_same   = (step_diff == '0);
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign step_one    = ~step_same & ((step_diff & (step_diff - ONE_DIFF())) == '0);

    function automatic logic [NBIT-1:0] ONE_DIFF();
        return NBIT'(1);
    endfunction

`ifdef GRAY_DIR_CHECK_EN
    assign bin_prev = gray2bin(gprev_q);
    assign step_up  = ((bin_new - bin_prev) == ONE);
    assign dir_bad  = step_one & dir_vld_q & (dir_q != ~step_up);
    assign o_dir    = dir_q;
`else
    assign dir_bad  = 1'b0;
    assign o_dir    = 1'b0;
`endif

    assign good        = step_one & ~dir_bad;
    assign bad         = (~step_one & ~step_same) | dir_bad;
    assign bad_acc     = accept & (state_q != ST_HUNT) & bad;

    assign o_bin       = bin_q;
    assign o_valid     = valid_q;
    assign o_locked    = (state_q == ST_LOCKED);
    assign o_err_pulse = err_q;
    assign o_err_cnt   = cnt_q;
    assign o_dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        gprev_d = gprev_q;
        valid_d = valid_q;
        bin_d   = bin_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef GRAY_DIR_CHECK_EN
        dir_d     = dir_q;
        dir_vld_d = dir_vld_q;
`endif
        if (accept) begin
            valid_d = 1'b1;
            bin_d   = bin_new;
            gprev_d = i_gray;
            err_d   = 1'b0;
            case (state_q)
                ST_HUNT: begin
                    state_d = ST_ACQ;
                    good_d  = '0;
                end
                ST_ACQ: begin
                    if (bad) begin
                        good_d = '0;
                        err_d  = 1'b1;
                    end else if (good) begin
                        good_d = good_q + GCW'(1);
                        if (int'(good_q) + 1 >= LOCK_CNT) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bad) begin
                        state_d = ST_ACQ;
                        good_d  = '0;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    good_d  = '0;
                end
            endcase
`ifdef GRAY_DIR_CHECK_EN
            // A bad step forgets the direction; the next good step re-latches it.
            if (state_q != ST_HUNT) begin
                if (bad) begin
                    dir_vld_d = 1'b0;
                end else if (good && !dir_vld_q) begin
                    dir_vld_d = 1'b1;
                    dir_d     = ~step_up;
                end
            end
`endif
        end else if (i_ready) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
        end

        if (i_clr_err) begin
            cnt_d = '0;
        end else if (bad_acc && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_HUNT;
            good_q  <= '0;
            gprev_q <= '0;
            valid_q <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            gprev_q <= gprev_d;
            valid_q <= valid_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef GRAY_DIR_CHECK_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dir_q     <= 1'b0;
            dir_vld_q <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            dir_vld_q <= dir_vld_d;
        end
    end
`endif

endmodule

// File: tb/tb_gray_stream_rx.sv
// Scoreboard bench for gray_stream_rx: driver pushes model expectations, monitor pops on output transfers.
module tb_gray_stream_rx;

  localparam int NBIT = 8;
  localparam int ECW  = 8;
  localparam int LOCK = 4;
  localparam int EW   = NBIT + ECW + 3;

  logic            clk;
  logic            i_rst;
  logic [NBIT-1:0] i_gray;
  logic            i_valid;
  logic            o_ready;
  logic [NBIT-1:0] o_bin;
  logic            o_valid;
  logic            i_ready;
  logic            o_locked;
  logic            o_err_pulse;
  logic [ECW-1:0]  o_err_cnt;
  logic            i_clr_err;
  logic            o_dir;
  logic [1:0]      dbg_state;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  // reference model state
  bit              m_has_prev;
  bit              m_locked;
  int              m_good;
  logic [NBIT-1:0] m_gprev;
  logic [NBIT-1:0] m_bprev;
  int              m_cnt;
  bit              m_dir;
  bit              m_dir_known;

  bit rdy_random;
  int epoch;

  gray_stream_rx #(.NBIT(NBIT), .ERR_CNT_W(ECW), .LOCK_CNT(LOCK)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_gray(i_gray), .i_valid(i_valid), .o_ready(o_ready),
    .o_bin(o_bin), .o_valid(o_valid), .i_ready(i_ready), .o_locked(o_locked),
    .o_err_pulse(o_err_pulse), .o_err_cnt(o_err_cnt), .i_clr_err(i_clr_err),
    .o_dir(o_dir), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NBIT-1:0] to_gray(input logic [NBIT-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // binary is the XOR of every right shift of the Gray code
  function automatic logic [NBIT-1:0] from_gray(input logic [NBIT-1:0] g);
    logic [NBIT-1:0] b = '0;
    for (int s = 0; s < NBIT; s++) b ^= (g >> s);
    return b;
  endfunction

  function automatic void model_reset();
    m_has_prev = 0; m_locked = 0; m_good = 0; m_gprev = '0; m_bprev = '0;
    m_cnt = 0; m_dir = 0; m_dir_known = 0;
  endfunction

  function automatic logic [EW-1:0] model_step(input logic [NBIT-1:0] g, input bit clr);
    logic [NBIT-1:0] b, delta;
    int d;
    bit bad, up;
    b = from_gray(g);
    bad = 0;
    if (!m_has_prev) begin
      m_has_prev = 1; m_locked = 0; m_good = 0;
    end else begin
      d = $countones(g ^ m_gprev);
      delta = b - m_bprev;
      up = (delta == 1);
      if (d == 1) begin
`ifdef GRAY_DIR_CHECK_EN
        if (m_dir_known && (m_dir != !up)) bad = 1;
        else if (!m_dir_known) begin m_dir_known = 1; m_dir = !up; end
`endif
        if (!bad && !m_locked) begin
          m_good++;
          if (m_good >= LOCK) m_locked = 1;
        end
      end else if (d >= 2) begin
        bad = 1;
      end
      if (bad) begin
        m_locked = 0; m_good = 0; m_dir_known = 0;
      end
    end
    m_gprev = g;
    m_bprev = b;
    if (clr) m_cnt = 0;
    else if (bad && m_cnt < (1 << ECW) - 1) m_cnt++;
    return {m_dir, ECW'(m_cnt), bad, m_locked, b};
  endfunction

  // driver tasks
  task automatic send(input logic [NBIT-1:0] g, input bit clr);
    int waited = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_gray = g;
      i_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_clr_err = clr && i_ready;
      #1;
      if (o_ready) begin
        done = 1;
        exp_q.push_back(model_step(g, i_clr_err));
      end else if (++waited > 50) begin
        done = 1;
        chk("accept_timeout", 32'(waited), 32'd0);
      end
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_clr_err = 1'b0;
      i_ready = rdy;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_valid = 1'b0; i_clr_err = 1'b0; i_ready = 1'b0;
    #3 i_rst = 1'b1;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_bin", 32'(o_bin), 32'd0);
    chk("rst_locked", 32'(o_locked), 32'd0);
    chk("rst_err_pulse", 32'(o_err_pulse), 32'd0);
    chk("rst_err_cnt", 32'(o_err_cnt), 32'd0);
    chk("rst_dir", 32'(o_dir), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    exp_q.delete();
    model_reset();
    epoch++;
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  // monitor / scoreboard
  bit              hold_pend = 0;
  int              hold_epoch = 0;
  logic [NBIT-1:0] hold_bin;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    #2;
    if (!i_rst) begin
      if (hold_pend && hold_epoch == epoch) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_bin", 32'(o_bin), 32'(hold_bin));
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", 32'(o_bin), 32'hffffffff);
        end else begin
          e = exp_q.pop_front();
          chk("bin", 32'(o_bin), 32'(e[NBIT-1:0]));
          chk("locked", 32'(o_locked), 32'(e[NBIT]));
          chk("err_pulse", 32'(o_err_pulse), 32'(e[NBIT+1]));
          chk("err_cnt", 32'(o_err_cnt), 32'(e[NBIT+2 +: ECW]));
          chk("dir", 32'(o_dir), 32'(e[EW-1]));
        end
      end
      hold_pend = o_valid && !i_ready;
      hold_bin = o_bin;
      hold_epoch = epoch;
    end
  end

  // stimulus
  logic [NBIT-1:0] cur_b;
  logic [NBIT-1:0] g;
  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_gray = '0; i_ready = 1'b1; i_clr_err = 1'b0;
    rdy_random = 0; epoch = 0;
    model_reset();
    #1;
    chk("init_valid", 32'(o_valid), 32'd0);
    chk("init_cnt", 32'(o_err_cnt), 32'd0);
    repeat (2) @(negedge clk);
    i_rst = 1'b0;

    // acquire and lock on bin 0..4
    send(8'h00, 0); send(8'h01, 0); send(8'h03, 0); send(8'h02, 0); send(8'h06, 0);
    // bad step while locked, then four good steps relock
    send(8'h05, 0); send(8'h04, 0); send(8'h0C, 0); send(8'h0D, 0); send(8'h0F, 0);
    // jump to top of range, then legal wrap to zero
    send(8'h80, 0); send(8'h00, 0);
    // repeats in ACQ, then a bad step coinciding with error clear
    send(8'h02, 0); send(8'h02, 0); send(8'h02, 0); send(8'h02, 0);
    send(8'h55, 1);
    idle(2, 1);

    // backpressure: output held for three cycles, then accepted on release
    send(8'h57, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_valid = 1'b1; i_gray = 8'h56; i_ready = 1'b0; i_clr_err = 1'b0;
      #1;
      chk("bp_ready_low", 32'(o_ready), 32'd0);
    end
    send(8'h56, 0);
    send(8'h52, 0);

    // reset while an output is pending, next sample starts fresh
    do_reset();
    send(8'h33, 0); send(8'h32, 0);
`ifdef GRAY_DIR_CHECK_EN
    do_reset();
    send(8'h00, 0); send(8'h01, 0); send(8'h03, 0); send(8'h01, 0);
`endif
    idle(2, 1);

    // randomized walk with backpressure, repeats, jumps and clears
    rdy_random = 1;
    cur_b = NBIT'($urandom_range(0, 255));
    for (int n = 0; n < 600; n++) begin
      int r = $urandom_range(0, 9);
      if (r < 4) cur_b = cur_b + 1;
      else if (r < 6) cur_b = cur_b - 1;
      else if (r >= 8) cur_b = NBIT'($urandom_range(0, 255));
      send(to_gray(cur_b), $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end
    idle(3, 1);

    // drive the error counter into saturation, then clear it with a good step
    rdy_random = 0;
    g = 8'h10;
    for (int n = 0; n < 270; n++) begin
      g = g ^ 8'h03;
      send(g, 0);
    end
    send(g ^ 8'h40, 1);
    send(g ^ 8'h41, 0);
    idle(4, 1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
